// File: rtl/mtm_alu_deserializer.sv
// Serial frame receiver for the ALU input: decodes DATA/CTL frames, assembles operands,
// and reports exactly one of valid/err_data/err_crc/err_op when a control frame closes a packet.
module mtm_alu_deserializer #(
  parameter int OPERAND_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic [2:0]           op,
  output logic                 valid,
  output logic                 err_data,
  output logic                 err_crc,
  output logic                 err_op
);

  localparam int BUF_W  = 2 * OPERAND_W;
  localparam int NBYTES = BUF_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBYTES + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TYPE      = 3'd1;
  localparam logic [2:0] ST_PAYLOAD   = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic [2:0]           state_r;
  logic [2:0]           bit_cnt_r;
  logic                 frame_type_r;
  logic [7:0]           payload_r;
  logic [CNT_W-1:0]     byte_cnt_r;
  logic [BUF_W-1:0]     buf_r;
  logic [OPERAND_W-1:0] a_r;
  logic [OPERAND_W-1:0] b_r;
  logic [2:0]           op_r;
  logic                 valid_r;
  logic                 err_data_r;
  logic                 err_crc_r;
  logic                 err_op_r;

  logic [2:0] ctl_op_s;
  logic [3:0] ctl_crc_s;
  logic [3:0] crc_exp_s;
  logic       op_ok_s;

  // CRC4 (x^4+x+1), init 0, fed MSB first one bit at a time
  function automatic logic [3:0] crc4_f(input logic [BUF_W+3:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = BUF_W + 3; i >= 0; i--) begin
      fb = d[i] ^ c[3];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // Decode the control payload and precompute the checks used at the stop bit
  always_comb begin
    ctl_op_s  = payload_r[6:4];
    ctl_crc_s = payload_r[3:0];
    crc_exp_s = crc4_f({buf_r, 1'b1, payload_r[6:4]});
    case (payload_r[6:4])
      3'b000:  op_ok_s = 1'b1;
      3'b001:  op_ok_s = 1'b1;
      3'b100:  op_ok_s = 1'b1;
      3'b101:  op_ok_s = 1'b1;
      default: op_ok_s = 1'b0;
    endcase
  end

  // Frame FSM, packet assembly and registered result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      frame_type_r <= 1'b0;
      payload_r    <= 8'h00;
      byte_cnt_r   <= '0;
      buf_r        <= '0;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= 3'b000;
      valid_r      <= 1'b0;
      err_data_r   <= 1'b0;
      err_crc_r    <= 1'b0;
      err_op_r     <= 1'b0;
    end else begin
      valid_r    <= 1'b0;
      err_data_r <= 1'b0;
      err_crc_r  <= 1'b0;
      err_op_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!sin) state_r <= ST_TYPE;
        end
        ST_TYPE: begin
          frame_type_r <= sin;
          bit_cnt_r    <= 3'd0;
          state_r      <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          payload_r <= {payload_r[6:0], sin};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) state_r <= ST_STOP;
        end
        ST_STOP: begin
          if (!sin) begin
            // Framing error kills the whole packet in progress
            err_data_r <= 1'b1;
            byte_cnt_r <= '0;
            state_r    <= ST_WAIT_IDLE;
          end else if (frame_type_r) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= '0;
            if (byte_cnt_r != CNT_FULL) begin
              err_data_r <= 1'b1;
            end else if (ctl_crc_s != crc_exp_s) begin
              err_crc_r <= 1'b1;
            end else if (!op_ok_s) begin
              err_op_r <= 1'b1;
            end else begin
              b_r     <= buf_r[BUF_W-1:OPERAND_W];
              a_r     <= buf_r[OPERAND_W-1:0];
              op_r    <= ctl_op_s;
              valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            buf_r   <= {buf_r[BUF_W-9:0], payload_r};
            if (byte_cnt_r != CNT_SAT) byte_cnt_r <= byte_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (sin) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign A        = a_r;
  assign B        = b_r;
  assign op       = op_r;
  assign valid    = valid_r;
  assign err_data = err_data_r;
  assign err_crc  = err_crc_r;
  assign err_op   = err_op_r;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result pulse appears.
module tb_mtm_alu_deserializer;

  localparam logic [2:0] K_VALID = 3'd0;
  localparam logic [2:0] K_EDATA = 3'd1;
  localparam logic [2:0] K_ECRC  = 3'd2;
  localparam logic [2:0] K_EOP   = 3'd3;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        valid;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;
  logic [31:0] mdl_a;
  logic [31:0] mdl_b;
  logic [2:0]  mdl_op;

  mtm_alu_deserializer #(.OPERAND_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .A(A), .B(B), .op(op),
    .valid(valid), .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference CRC over {B, A, 1, op}, 68 bits MSB first
  function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
    logic [67:0] v;
    logic [3:0]  r;
    logic        f;
    v = {b, a, 1'b1, o};
    r = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      f = v[i] ^ r[3];
      r = {r[2], r[1], r[0] ^ f, f};
    end
    return r;
  endfunction

  // Monitor: every result pulse consumes one scoreboard entry
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t       e;
    if (rst_n && (valid || err_data || err_crc || err_op)) begin
      case ({valid, err_data, err_crc, err_op})
        4'b1000: got = K_VALID;
        4'b0100: got = K_EDATA;
        4'b0010: got = K_ECRC;
        4'b0001: got = K_EOP;
        default: got = 3'd7;
      endcase
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", got);
      end else begin
        e = sb_q.pop_front();
        check("kind", {29'd0, got}, {29'd0, e.kind});
        check("A", A, e.a);
        check("B", B, e.b);
        check("op", {29'd0, op}, {29'd0, e.op});
      end
    end
  end

  task automatic expect_res(input logic [2:0] kind, input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
    exp_t e;
    if (kind == K_VALID) begin
      mdl_a  = a;
      mdl_b  = b;
      mdl_op = o;
    end
    e.kind = kind;
    e.a    = mdl_a;
    e.b    = mdl_b;
    e.op   = mdl_op;
    sb_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int n);
    logic [63:0] ba;
    ba = {b, a};
    for (int i = 0; i < n; i++) send_frame(1'b0, ba[63 - 8 * (i % 8) -: 8], 1'b1);
  endtask

  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                          input logic [3:0] crc, input int n, input logic [2:0] kind);
    expect_res(kind, b, a, o);
    send_data(b, a, n);
    send_frame(1'b1, {1'b0, o, crc}, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_A"}, A, 32'd0);
    check({tag, "_B"}, B, 32'd0);
    check({tag, "_op"}, {29'd0, op}, 32'd0);
    check({tag, "_pulses"}, {28'd0, valid, err_data, err_crc, err_op}, 32'd0);
  endtask

  initial begin
    logic [2:0]  ops[4];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  ro;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;
    n_cmp = 0; n_bad = 0;
    mdl_a = 32'd0; mdl_b = 32'd0; mdl_op = 3'd0;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 1) all-zero operands, hand-computed crc 4'hB
    send_pkt(32'd0, 32'd0, 3'b000, 4'hB, 8, K_VALID);
    idle(3);

    // 2) all-ones and all-zero operands with each supported opcode
    for (int i = 0; i < 4; i++)
      send_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, ops[i], ref_crc(32'hFFFF_FFFF, 32'hFFFF_FFFF, ops[i]), 8, K_VALID);
    for (int i = 0; i < 4; i++)
      send_pkt(32'd0, 32'd0, ops[i], ref_crc(32'd0, 32'd0, ops[i]), 8, K_VALID);
    idle(3);

    // 3) wrong frame counts, then recovery
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'h0, 7, K_EDATA);
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'h0, 9, K_EDATA);
    send_pkt(32'h0, 32'h0, 3'b000, 4'h0, 0, K_EDATA);
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b100), 8, K_VALID);
    idle(3);

    // 4) bad crc keeps previous operands
    send_pkt(32'd0, 32'd0, 3'b000, 4'hA, 8, K_ECRC);
    idle(3);

    // 5) unsupported opcode, then framing error, then recovery
    send_pkt(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b010, ref_crc(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b010), 8, K_EOP);
    expect_res(K_EDATA, 32'd0, 32'd0, 3'd0);
    send_data(32'hCAFE_0001, 32'h0000_BEEF, 2);
    send_frame(1'b0, 8'h55, 1'b0);
    idle(3);
    send_pkt(32'hCAFE_0001, 32'h0000_BEEF, 3'b101, ref_crc(32'hCAFE_0001, 32'h0000_BEEF, 3'b101), 8, K_VALID);
    idle(3);

    // 6) random back-to-back packets with one mid-payload reset
    for (int p = 0; p < 800; p++) begin
      if (p == 300) begin
        idle(4);
        send_data(32'hAAAA_5555, 32'h0F0F_F0F0, 2);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst_n = 1'b0;
        mdl_a = 32'd0; mdl_b = 32'd0; mdl_op = 3'd0;
        #2;
        check_zero("midreset");
        @(posedge clk);
        #1;
        sin   = 1'b1;
        rst_n = 1'b1;
        idle(2);
      end
      ra = $urandom;
      rb = $urandom;
      ro = ops[$urandom_range(3, 0)];
      send_pkt(rb, ra, ro, ref_crc(rb, ra, ro), 8, K_VALID);
    end

    idle(1);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle(1);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results still pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
